// File: rtl/shift_issue_ctrl_if.sv
// shift_issue_ctrl_if
//   Bundles the request handshake, the SHIFT32 drive/return bus and the result
//   handshake of shift_issue_ctrl.
//   slave  : the sequencer side (shift_issue_ctrl itself)
//   master : the environment side (ALU decode, SHIFT32, result consumer)
//   REQ_*  : request valid/ready, op code, operand, shift amount
//   SH_*   : SHIFT32 D/S/LnR drive and combinational Y return
//   RES_*  : result valid/ready, data, zero/carry/error flags
interface shift_issue_ctrl_if;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [1:0]  REQ_OP;
    logic [31:0] REQ_A;
    logic [4:0]  REQ_AMT;
    logic [31:0] SH_D;
    logic [31:0] SH_S;
    logic        SH_LNR;
    logic [31:0] SH_Y;
    logic        RES_VALID;
    logic        RES_READY;
    logic [31:0] RES_DATA;
    logic        RES_ZERO;
    logic        RES_CARRY;
    logic        RES_ERR;

    modport slave (
        input  REQ_VALID, REQ_OP, REQ_A, REQ_AMT, SH_Y, RES_READY,
        output REQ_READY, SH_D, SH_S, SH_LNR,
               RES_VALID, RES_DATA, RES_ZERO, RES_CARRY, RES_ERR
    );

    modport master (
        output REQ_VALID, REQ_OP, REQ_A, REQ_AMT, SH_Y, RES_READY,
        input  REQ_READY, SH_D, SH_S, SH_LNR,
               RES_VALID, RES_DATA, RES_ZERO, RES_CARRY, RES_ERR
    );
endinterface

// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl
//   Sequencer in front of the SHIFT32 barrel shifter. Takes a shift request,
//   drives SHIFT32 for one pass (SLL, SRL) or two passes (SRA of a negative
//   operand, ROL), and returns a registered result with zero/carry flags.
//   Ports:
//     CLK : clock, all state on the rising edge
//     RST : synchronous active-high reset
//     bus : shift_issue_ctrl_if.slave (request, SHIFT32 and result handshakes)
//   Optional feature macro: SHIFT_ROTATE_EN
//     defined   : ROL (op 11) is a legal two-pass operation
//     undefined : op 11 completes as an illegal op with RES_ERR=1
module shift_issue_ctrl (
    input  logic              CLK,
    input  logic              RST,
    shift_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} stateT;
    typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01,
                              OP_SRA = 2'b10, OP_ROL = 2'b11} opT;

    stateT       state;
    opT          opReg;
    logic [31:0] aReg;
    logic [4:0]  amtReg;
    logic [31:0] tmp;

    logic        reqReady;
    logic        resValid;
    logic [31:0] resData;
    logic        resZero;
    logic        resCarry;
    logic        resErr;
    logic [31:0] shD;
    logic [31:0] shS;
    logic        shLnr;

    logic        illegalOp;
    logic        needPass2;
    logic        carryLin;
    logic [31:0] pass2Res;
    logic [4:0]  sllIdx;
    logic [4:0]  srlIdx;

    always_comb begin
        // Amount is 1..31 whenever these indices are used, so 32-AMT fits in
        // five bits as the two's complement of AMT.
        sllIdx = 5'd0 - amtReg;
        srlIdx = amtReg - 5'd1;
        if (amtReg == '0)
            carryLin = 1'b0;
        else if (opReg == OP_SLL)
            carryLin = aReg[sllIdx];
        else
            carryLin = aReg[srlIdx];
`ifdef SHIFT_ROTATE_EN
        illegalOp = 1'b0;
        needPass2 = (amtReg != '0) &&
                    (((opReg == OP_SRA) && aReg[31]) || (opReg == OP_ROL));
        // ROL ORs in the wrapped-around bits; SRA ORs in the sign fill,
        // which is the complement of a logical right shift of all-ones.
        pass2Res  = (opReg == OP_ROL) ? (tmp | bus.SH_Y) : (tmp | ~bus.SH_Y);
`else
        illegalOp = (opReg == OP_ROL);
        needPass2 = (amtReg != '0) && (opReg == OP_SRA) && aReg[31];
        pass2Res  = tmp | ~bus.SH_Y;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            opReg    <= OP_SLL;
            aReg     <= '0;
            amtReg   <= '0;
            tmp      <= '0;
            reqReady <= 1'b1;
            resValid <= 1'b0;
            resData  <= '0;
            resZero  <= 1'b0;
            resCarry <= 1'b0;
            resErr   <= 1'b0;
            shD      <= '0;
            shS      <= '0;
            shLnr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.REQ_VALID) begin
                        opReg    <= opT'(bus.REQ_OP);
                        aReg     <= bus.REQ_A;
                        amtReg   <= bus.REQ_AMT;
                        reqReady <= 1'b0;
                        shD      <= bus.REQ_A;
                        shS      <= {27'd0, bus.REQ_AMT};
                        shLnr    <= (bus.REQ_OP == OP_SLL) || (bus.REQ_OP == OP_ROL);
                        state    <= PASS1;
                    end
                end

                PASS1: begin
                    if (illegalOp) begin
                        resData  <= '0;
                        resZero  <= 1'b1;
                        resCarry <= 1'b0;
                        resErr   <= 1'b1;
                        resValid <= 1'b1;
                        shD      <= '0;
                        shS      <= '0;
                        shLnr    <= 1'b0;
                        state    <= DONE;
                    end else if (needPass2) begin
                        tmp   <= bus.SH_Y;
                        shLnr <= 1'b0;
                        state <= PASS2;
`ifdef SHIFT_ROTATE_EN
                        if (opReg == OP_ROL) begin
                            shD <= aReg;
                            shS <= 32'd32 - {27'd0, amtReg};
                        end else begin
                            shD <= '1;
                            shS <= {27'd0, amtReg};
                        end
`else
                        shD <= '1;
                        shS <= {27'd0, amtReg};
`endif
                    end else begin
                        resData  <= bus.SH_Y;
                        resZero  <= (bus.SH_Y == '0);
                        resCarry <= carryLin;
                        resErr   <= 1'b0;
                        resValid <= 1'b1;
                        shD      <= '0;
                        shS      <= '0;
                        shLnr    <= 1'b0;
                        state    <= DONE;
                    end
                end

                PASS2: begin
                    resData  <= pass2Res;
                    resZero  <= (pass2Res == '0);
                    resCarry <= (opReg == OP_ROL) ? pass2Res[0] : carryLin;
                    resErr   <= 1'b0;
                    resValid <= 1'b1;
                    shD      <= '0;
                    shS      <= '0;
                    shLnr    <= 1'b0;
                    state    <= DONE;
                end

                DONE: begin
                    if (bus.RES_READY) begin
                        resValid <= 1'b0;
                        reqReady <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.REQ_READY = reqReady;
    assign bus.RES_VALID = resValid;
    assign bus.RES_DATA  = resData;
    assign bus.RES_ZERO  = resZero;
    assign bus.RES_CARRY = resCarry;
    assign bus.RES_ERR   = resErr;
    assign bus.SH_D      = shD;
    assign bus.SH_S      = shS;
    assign bus.SH_LNR    = shLnr;

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// tb_shift_issue_ctrl
//   Directed and random shift requests against shift_issue_ctrl, with SHIFT32
//   modelled as a combinational shifter on the interface. Expected results
//   come from a whole-word arithmetic reference of each shift operation.
//   Honours SHIFT_ROTATE_EN the same way as the design.
module tb_shift_issue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    shift_issue_ctrl_if bus ();

    shift_issue_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // SHIFT32 stand-in: logical shift, direction from LnR
    assign bus.SH_Y = bus.SH_LNR ? (bus.SH_D << bus.SH_S) : (bus.SH_D >> bus.SH_S);

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void refModel(input logic [1:0] op, input logic [31:0] a,
                                     input logic [4:0] amt, output logic [31:0] data,
                                     output logic carry, output logic err, output int passes);
        logic [63:0] t;
        bit rolLegal;
`ifdef SHIFT_ROTATE_EN
        rolLegal = 1'b1;
`else
        rolLegal = 1'b0;
`endif
        err = 1'b0;
        passes = 1;
        case (op)
            2'd0: begin
                t = {32'd0, a} << amt;
                data = t[31:0];
                carry = t[32];
            end
            2'd1: begin
                t = {a, 32'd0} >> amt;
                data = t[63:32];
                carry = t[31];
            end
            2'd2: begin
                t = $signed({a, 32'd0}) >>> amt;
                data = t[63:32];
                carry = t[31];
                if (amt != 0 && a[31]) passes = 2;
            end
            default: begin
                if (rolLegal) begin
                    t = {a, a} << amt;
                    data = t[63:32];
                    carry = (amt != 0) ? data[0] : 1'b0;
                    if (amt != 0) passes = 2;
                end else begin
                    data = '0;
                    carry = 1'b0;
                    err = 1'b1;
                end
            end
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a,
                         input logic [4:0] amt, input int hold);
        logic [31:0] expData;
        logic expCarry, expErr;
        int passes;
        refModel(op, a, amt, expData, expCarry, expErr, passes);

        check("req_ready_idle", bus.REQ_READY, 1);
        bus.REQ_VALID = 1'b1;
        bus.REQ_OP = op;
        bus.REQ_A = a;
        bus.REQ_AMT = amt;
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        bus.REQ_A = $urandom;
        // PASS1
        check("p1_res_valid", bus.RES_VALID, 0);
        check("p1_req_ready", bus.REQ_READY, 0);
        if (!expErr) begin
            check("p1_sh_d", bus.SH_D, a);
            check("p1_sh_s", bus.SH_S, {27'd0, amt});
            check("p1_sh_lnr", bus.SH_LNR, (op == 2'd0 || op == 2'd3) ? 1 : 0);
        end
        if (passes == 2) begin
            @(negedge clk);
            check("p2_res_valid", bus.RES_VALID, 0);
            check("p2_sh_lnr", bus.SH_LNR, 0);
            if (op == 2'd2) begin
                check("p2_sra_sh_d", bus.SH_D, 32'hFFFF_FFFF);
                check("p2_sra_sh_s", bus.SH_S, {27'd0, amt});
            end else begin
                check("p2_rol_sh_d", bus.SH_D, a);
                check("p2_rol_sh_s", bus.SH_S, 32 - amt);
            end
        end
        @(negedge clk);
        check("done_res_valid", bus.RES_VALID, 1);
        check("done_data", bus.RES_DATA, expData);
        check("done_zero", bus.RES_ZERO, (expData == 0) ? 1 : 0);
        check("done_carry", bus.RES_CARRY, expCarry);
        check("done_err", bus.RES_ERR, expErr);
        check("done_req_ready", bus.REQ_READY, 0);
        check("done_sh_d", bus.SH_D, 0);
        for (int i = 0; i < hold; i++) begin
            bus.REQ_VALID = (i == 2);
            bus.REQ_OP = 2'd0;
            @(negedge clk);
            check("hold_res_valid", bus.RES_VALID, 1);
            check("hold_data", bus.RES_DATA, expData);
            check("hold_req_ready", bus.REQ_READY, 0);
        end
        bus.REQ_VALID = 1'b0;
        bus.RES_READY = 1'b1;
        @(negedge clk);
        bus.RES_READY = 1'b0;
        check("consumed_res_valid", bus.RES_VALID, 0);
        check("consumed_req_ready", bus.REQ_READY, 1);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [4:0]  ramt;
        int sel;

        bus.REQ_VALID = 1'b0;
        bus.REQ_OP = '0;
        bus.REQ_A = '0;
        bus.REQ_AMT = '0;
        bus.RES_READY = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.REQ_READY, 1);
        check("rst_res_valid", bus.RES_VALID, 0);
        check("rst_res_data", bus.RES_DATA, 0);
        check("rst_flags", {bus.RES_ZERO, bus.RES_CARRY, bus.RES_ERR}, 0);
        check("rst_sh", {bus.SH_LNR, bus.SH_D | bus.SH_S}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, including 5 cycles of result backpressure on the first
        runOp(2'd0, 32'h0000_0008, 5'd2, 5);
        runOp(2'd1, 32'h0000_0008, 5'd4, 0);
        runOp(2'd2, 32'h8000_0000, 5'd4, 0);
        runOp(2'd3, 32'h8000_0001, 5'd4, 0);
        runOp(2'd2, 32'h8000_0000, 5'd0, 0);
        runOp(2'd0, 32'h0000_0001, 5'd31, 0);
        runOp(2'd1, 32'h8000_0000, 5'd31, 0);
        runOp(2'd3, 32'h1234_5678, 5'd0, 0);
        runOp(2'd2, 32'hFFFF_FFFF, 5'd31, 2);

        // Reset while an SRA is in its second pass
        bus.REQ_VALID = 1'b1;
        bus.REQ_OP = 2'd2;
        bus.REQ_A = 32'h8000_0010;
        bus.REQ_AMT = 5'd3;
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        @(negedge clk);
        check("pre_rst_p2_sh_d", bus.SH_D, 32'hFFFF_FFFF);
        rst = 1'b1;
        bus.RES_READY = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.RES_READY = 1'b0;
        check("midrst_res_valid", bus.RES_VALID, 0);
        check("midrst_req_ready", bus.REQ_READY, 1);
        check("midrst_sh_d", bus.SH_D, 0);
        check("midrst_sh_s", bus.SH_S, 0);
        check("midrst_sh_lnr", bus.SH_LNR, 0);
        check("midrst_res_data", bus.RES_DATA, 0);
        repeat (2) @(negedge clk);
        check("midrst_stays_idle", {bus.RES_VALID, bus.REQ_READY}, 2'b01);

        // Random requests
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) ramt = 5'd0;
            else if (sel == 1) ramt = 5'd31;
            else ramt = 5'($urandom_range(1, 30));
            if ($urandom_range(0, 7) == 0) ra = '0;
            runOp(rop, ra, ramt, (n % 7 == 3) ? 3 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
